// File: rtl/hex_counter_pkg.sv
// Shared constants for the hex counter / seven-segment demo.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g} with a in bit 6.
package hex_counter_pkg;

    localparam int DIV_DEFAULT = 10;
    localparam int SEG_W       = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg7
    import hex_counter_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_counter_seg7_top.sv
// Up/down hex counter stepped by a free-running prescaler, with a 7-segment decode.
// The step strobe sits mid-period so count changes never coincide with DIV-aligned samples.
module hex_counter_seg7_top
    import hex_counter_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             upDown,
    output logic [CNT_W-1:0] count,
    output logic [SEG_W-1:0] seg7
);

    localparam int              PS_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(DIV - 1);
    localparam logic [PS_W-1:0] PS_STROBE = PS_W'(DIV / 2 - 1);

    logic [PS_W-1:0]  prescaler_reg;
    logic [PS_W-1:0]  prescaler_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             step_strobe;

    // Prescaler keeps running while disabled so the step phase is preserved.
    always_comb begin
        prescaler_next = prescaler_reg + 1'b1;
        if (prescaler_reg == PS_LAST) begin
            prescaler_next = '0;
        end
    end

    assign step_strobe = (prescaler_reg == PS_STROBE);

    always_comb begin
        count_next = count_reg - 1'b1;
        if (upDown) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_reg <= '0;
            count_reg     <= '0;
        end else begin
            prescaler_reg <= prescaler_next;
            if (step_strobe && enable) begin
                count_reg <= count_next;
            end
        end
    end

    assign count = count_reg;

    hex_to_seg7 u_hex_to_seg7 (
        .hex (count_reg),
        .seg (seg7)
    );

endmodule

// File: tb/tb_hex_counter_seg7_top.sv
// Directed bench for hex_counter_seg7_top with DIV=10: reset, down/up counting,
// enable hold, direction change, mid-count reset and step timing.
module tb_hex_counter_seg7_top;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       upDown;
    logic [3:0] count;
    logic [6:0] seg7;

    int vectors;
    int miscompares;

    localparam logic [6:0] EXP_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    hex_counter_seg7_top #(.DIV(10), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .upDown (upDown),
        .count  (count),
        .seg7   (seg7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] exp_cnt);
        logic [6:0] exp_s;
        exp_s = EXP_SEG[exp_cnt];
        vectors++;
        $display("vec %0d %s: count=%h seg7=%b (want %h/%b)", vectors, tag, count, seg7, exp_cnt, exp_s);
        assert (count === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s count: observed %h expected %h", tag, count, exp_cnt);
        end
        assert (seg7 === exp_s) else begin
            miscompares++;
            $error("FAIL %s seg7: observed %b expected %b", tag, seg7, exp_s);
        end
    endtask

    initial begin
        logic [3:0] exp_c;
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        enable = 1'b1;
        upDown = 1'b0;

        // Reset, then count down with step-timing boundaries.
        step(5);
        check("reset", 4'h0);
        rst = 1'b0;
        check("release", 4'h0);
        step(4);
        check("edge4_hold", 4'h0);
        step(1);
        check("edge5_first_step", 4'hF);
        step(5);
        check("down_10", 4'hF);
        step(4);
        check("edge14_hold", 4'hF);
        step(1);
        check("edge15_step", 4'hE);
        step(5);
        check("down_20", 4'hE);
        exp_c = 4'hE;
        for (int k = 3; k <= 16; k++) begin
            step(10);
            exp_c = exp_c - 4'h1;
            check("down", exp_c);
        end

        // Up count through F -> 0 wrap.
        rst    = 1'b1;
        upDown = 1'b1;
        step(2);
        check("reset_up", 4'h0);
        rst = 1'b0;
        exp_c = 4'h0;
        for (int k = 1; k <= 16; k++) begin
            step(10);
            exp_c = exp_c + 4'h1;
            check("up", exp_c);
        end

        // Enable hold at 5 for 40 cycles.
        step(50);
        check("up_to_5", 4'h5);
        enable = 1'b0;
        step(40);
        check("hold_5", 4'h5);
        enable = 1'b1;
        step(4);
        check("reenable_pre", 4'h5);
        step(1);
        check("reenable_step", 4'h6);
        step(5);
        check("reenable_stable", 4'h6);

        // Direction change between strobes at 3.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(30);
        check("dir_at_3", 4'h3);
        step(3);
        upDown = 1'b0;
        step(1);
        check("dir_pre", 4'h3);
        step(1);
        check("dir_step_2", 4'h2);
        step(10);
        check("dir_step_1", 4'h1);

        // Climb to A, then a one-cycle reset mid-period.
        upDown = 1'b1;
        step(90);
        check("up_to_A", 4'hA);
        step(3);
        rst = 1'b1;
        step(1);
        check("mid_reset", 4'h0);
        rst = 1'b0;
        step(4);
        check("post_reset_hold", 4'h0);
        step(1);
        check("post_reset_step", 4'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
